// File: rtl/cv32e40x_pkg.sv
// Shared types for the coprocessor (xif) result path.
package cv32e40x_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } xif_result_entry_t;

endpackage

// File: rtl/cv32e40x_xif_result_fifo.sv
// Circular FIFO holding coprocessor results; storage is unreset and qualified by the count.
module cv32e40x_xif_result_fifo
    import cv32e40x_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  xif_result_entry_t          data_i,
    input  logic                       pop_i,
    output xif_result_entry_t          head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH+1);

    xif_result_entry_t mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i && !full_o && !clear_i;
    assign pop_en  = pop_i && !empty_o && !clear_i;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cv32e40x_xif_result_buffer.sv
// Buffers coprocessor results until the matching instruction retires in WB.
// Optional CV32E40X_XIF_RESULT_BYPASS_EN forwards a result straight to WB when the buffer is empty.
module cv32e40x_xif_result_buffer
    import cv32e40x_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned X_ID_WIDTH = cv32e40x_pkg::X_ID_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       xif_result_valid_i,
    output logic                       xif_result_ready_o,
    input  xif_result_entry_t          xif_result_i,
    input  logic                       wb_xif_valid_i,
    input  logic [X_ID_WIDTH-1:0]      wb_xif_id_i,
    output logic                       wb_result_valid_o,
    output xif_result_entry_t          wb_result_o,
    input  logic                       wb_result_ready_i,
    input  logic                       kill_i,
    output logic                       id_err_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    xif_result_entry_t     head;
    logic                  empty, full;
    logic                  head_match, push, pop, bypass;
    logic [X_ID_WIDTH-1:0] head_id;
    logic                  id_err_q, id_err_d;

    assign head_id = X_ID_WIDTH'(head.id);

    assign xif_result_ready_o = !full;
    assign head_match = !empty && wb_xif_valid_i && (head_id == wb_xif_id_i) && !kill_i;

`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    assign bypass = empty && xif_result_valid_i && wb_xif_valid_i && !kill_i &&
                    (X_ID_WIDTH'(xif_result_i.id) == wb_xif_id_i);
`else
    assign bypass = 1'b0;
`endif

    assign wb_result_valid_o = head_match || bypass;
    assign pop = head_match && wb_result_ready_i;
    // A bypassed result consumed this cycle must not also be stored.
    assign push = xif_result_valid_i && xif_result_ready_o && !kill_i &&
                  !(bypass && wb_result_ready_i);

    always_comb begin
        wb_result_o = '0;
        if (!empty)      wb_result_o = head;
        else if (bypass) wb_result_o = xif_result_i;
    end

    always_comb begin
        id_err_d = id_err_q;
        if (kill_i) id_err_d = 1'b0;
        else if (wb_xif_valid_i && !empty && (head_id != wb_xif_id_i)) id_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) id_err_q <= 1'b0;
        else        id_err_q <= id_err_d;
    end

    assign id_err_o = id_err_q;

    cv32e40x_xif_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (kill_i),
        .push_i  (push),
        .data_i  (xif_result_i),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_cv32e40x_xif_result_buffer.sv
// Directed self-checking bench for the xif result buffer (DEPTH=2).
module tb_cv32e40x_xif_result_buffer;
    import cv32e40x_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              xif_result_valid_i;
    logic              xif_result_ready_o;
    xif_result_entry_t xif_result_i;
    logic              wb_xif_valid_i;
    logic [3:0]        wb_xif_id_i;
    logic              wb_result_valid_o;
    xif_result_entry_t wb_result_o;
    logic              wb_result_ready_i;
    logic              kill_i;
    logic              id_err_o;
    logic [1:0]        count_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cv32e40x_xif_result_buffer #(
        .DEPTH      (2),
        .X_ID_WIDTH (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .xif_result_valid_i (xif_result_valid_i),
        .xif_result_ready_o (xif_result_ready_o),
        .xif_result_i       (xif_result_i),
        .wb_xif_valid_i     (wb_xif_valid_i),
        .wb_xif_id_i        (wb_xif_id_i),
        .wb_result_valid_o  (wb_result_valid_o),
        .wb_result_o        (wb_result_o),
        .wb_result_ready_i  (wb_result_ready_i),
        .kill_i             (kill_i),
        .id_err_o           (id_err_o),
        .count_o            (count_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] id, input logic [31:0] data);
        xif_result_valid_i = v;
        xif_result_i       = '0;
        xif_result_i.id    = id;
        xif_result_i.data  = data;
        xif_result_i.rd    = 5'd7;
        xif_result_i.we    = 1'b1;
    endtask

    task automatic wb(input logic v, input logic [3:0] id, input logic rdy);
        wb_xif_valid_i    = v;
        wb_xif_id_i       = id;
        wb_result_ready_i = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        kill_i = 1'b0;
        offer(1'b0, 4'd0, 32'd0);
        wb(1'b0, 4'd0, 1'b0);
        #12;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(xif_result_ready_o), 64'd1);
        check("rst_valid", 64'(wb_result_valid_o), 64'd0);
        check("rst_result", 64'(wb_result_o), 64'd0);
        check("rst_id_err", 64'(id_err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic push then matched pop one cycle later
        offer(1'b1, 4'd3, 32'hDEADBEEF);
        #1;
        check("push_ready", 64'(xif_result_ready_o), 64'd1);
        check("push_no_valid", 64'(wb_result_valid_o), 64'd0);
        step();
        offer(1'b0, 4'd0, 32'd0);
        wb(1'b1, 4'd3, 1'b1);
        #1;
        check("pop_count_before", 64'(count_o), 64'd1);
        check("pop_valid", 64'(wb_result_valid_o), 64'd1);
        check("pop_data", 64'(wb_result_o.data), 64'hDEADBEEF);
        check("pop_rd", 64'(wb_result_o.rd), 64'd7);
        step();
        wb(1'b0, 4'd0, 1'b0);
        #1;
        check("pop_count_after", 64'(count_o), 64'd0);
        check("empty_result", 64'(wb_result_o), 64'd0);

        // Matching WB id in the arrival cycle: bypass forwards, otherwise one cycle later
        offer(1'b1, 4'd6, 32'h0000_1234);
        wb(1'b1, 4'd6, 1'b1);
        #1;
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
        check("byp_valid", 64'(wb_result_valid_o), 64'd1);
        check("byp_data", 64'(wb_result_o.data), 64'h1234);
        step();
        offer(1'b0, 4'd0, 32'd0);
        #1;
        check("byp_count", 64'(count_o), 64'd0);
`else
        check("nobyp_valid0", 64'(wb_result_valid_o), 64'd0);
        step();
        offer(1'b0, 4'd0, 32'd0);
        #1;
        check("nobyp_valid1", 64'(wb_result_valid_o), 64'd1);
        check("nobyp_data", 64'(wb_result_o.data), 64'h1234);
        step();
        #1;
        check("nobyp_count", 64'(count_o), 64'd0);
`endif
        wb(1'b0, 4'd0, 1'b0);

        // Fill to DEPTH, hold a third offer, then pop frees a slot
        offer(1'b1, 4'd1, 32'h11);
        step();
        offer(1'b1, 4'd2, 32'h22);
        step();
        offer(1'b1, 4'd9, 32'h99);
        #1;
        check("full_count", 64'(count_o), 64'd2);
        check("full_ready", 64'(xif_result_ready_o), 64'd0);
        step();
        check("held_count", 64'(count_o), 64'd2);
        check("held_head", 64'(wb_result_o.id), 64'd1);
        wb(1'b1, 4'd1, 1'b1);
        #1;
        check("full_pop_ready", 64'(xif_result_ready_o), 64'd0);
        step();
        wb(1'b0, 4'd0, 1'b0);
        offer(1'b0, 4'd0, 32'd0);
        #1;
        check("after_pop_count", 64'(count_o), 64'd1);
        check("after_pop_ready", 64'(xif_result_ready_o), 64'd1);
        check("after_pop_head", 64'(wb_result_o.id), 64'd2);

        // Simultaneous push and pop keep the count (also exercises pointer wrap)
        offer(1'b1, 4'd5, 32'h55);
        wb(1'b1, 4'd2, 1'b1);
        step();
        offer(1'b0, 4'd0, 32'd0);
        wb(1'b0, 4'd0, 1'b0);
        #1;
        check("pushpop_count", 64'(count_o), 64'd1);
        check("pushpop_head", 64'(wb_result_o.id), 64'd5);
        check("pushpop_data", 64'(wb_result_o.data), 64'h55);

        // ID mismatch: no valid, sticky error, cleared by kill (kill-cycle push dropped)
        wb(1'b1, 4'd7, 1'b1);
        #1;
        check("mis_valid", 64'(wb_result_valid_o), 64'd0);
        check("mis_err_now", 64'(id_err_o), 64'd0);
        step();
        wb(1'b0, 4'd0, 1'b0);
        #1;
        check("mis_err_set", 64'(id_err_o), 64'd1);
        step();
        check("mis_err_sticky", 64'(id_err_o), 64'd1);
        check("mis_count", 64'(count_o), 64'd1);
        kill_i = 1'b1;
        offer(1'b1, 4'd8, 32'h88);
        step();
        kill_i = 1'b0;
        offer(1'b0, 4'd0, 32'd0);
        #1;
        check("kill_count", 64'(count_o), 64'd0);
        check("kill_err", 64'(id_err_o), 64'd0);

        // Asynchronous reset mid-operation
        offer(1'b1, 4'd10, 32'hA0);
        step();
        offer(1'b1, 4'd11, 32'hB0);
        step();
        offer(1'b0, 4'd0, 32'd0);
        wb(1'b1, 4'd10, 1'b0);
        #1;
        check("prerst_count", 64'(count_o), 64'd2);
        check("prerst_valid", 64'(wb_result_valid_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_ready", 64'(xif_result_ready_o), 64'd1);
        check("arst_valid", 64'(wb_result_valid_o), 64'd0);
        check("arst_result", 64'(wb_result_o), 64'd0);
        check("arst_err", 64'(id_err_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
